// File: rtl/sprite_palette_pkg.sv
// Shared types and constants for the sprite palette lookup.
// Default palette is a 16-entry 4:4:4 table; wider/narrower channels are
// derived from it by left-aligning each 4-bit nibble.
package sprite_palette_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam int unsigned DEF_ENTRIES = 16;

    localparam logic [0:15][11:0] DEFAULT_PALETTE = {
        12'h000, 12'h000, 12'hFFF, 12'hF00,
        12'h0F0, 12'h00F, 12'hFF0, 12'h0FF,
        12'hF0F, 12'h888, 12'h444, 12'hF80,
        12'h840, 12'hFCA, 12'h08F, 12'h8F8
    };

    localparam logic [4:0] FLASH_FRAMES = 5'd16;

    // Index widths beyond 4 bits repeat the 16-entry default table.
    function automatic rgb_t default_rgb(input int unsigned idx);
        return rgb_t'(DEFAULT_PALETTE[idx % DEF_ENTRIES]);
    endfunction

    // Bank select width; a single bank still gets a 1-bit select.
    function automatic int bank_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/palette_bank_ram.sv
// One palette bank: single write port, single registered read port,
// storage returns to the default palette on asynchronous reset.
// A read and write of the same entry at one edge returns the old value.
module palette_bank_ram
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CH_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [3*CH_W-1:0]   wdata,
    input  logic                re,
    input  logic [IDX_W-1:0]    raddr,
    output logic [3*CH_W-1:0]   rdata
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int          DW      = 3 * CH_W;

    // Left-align a 4-bit default nibble into a CH_W-bit channel.
    function automatic logic [CH_W-1:0] scale_ch(input logic [3:0] n);
        logic [CH_W+3:0] wide;
        wide = {n, CH_W'(0)};
        return wide[CH_W+3:4];
    endfunction

    function automatic logic [DW-1:0] default_entry(input int unsigned idx);
        rgb_t e;
        e = default_rgb(idx);
        return {scale_ch(e.r), scale_ch(e.g), scale_ch(e.b)};
    endfunction

    logic [DW-1:0] mem_q [ENTRIES];
    logic [DW-1:0] mem_d [ENTRIES];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // Next-state for storage and read register; read sees pre-write contents.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Storage and read register, reset to the default palette.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= default_entry(i);
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    // Drive the registered read data out.
    always_comb begin
        rdata = rdata_q;
    end

endmodule

// File: rtl/sprite_palette_lut.sv
// Banked, runtime-writable sprite palette lookup with a 2-stage pipeline.
// Stage 1 registers the request; stage 2 is the bank read register plus
// registered result tags. Writes are gated by vblank when WR_VBLANK_ONLY=1.
// Optional hit-flash counter enabled by defining PALETTE_FLASH_EN.
module sprite_palette_lut
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W          = 4,
    parameter int CH_W           = 4,
    parameter int NUM_BANKS      = 4,
    parameter int TRANSP_IDX     = 0,
    parameter int TRANSP_EN      = 1,
    parameter int WR_VBLANK_ONLY = 1
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            in_valid,
    input  logic [bank_w(NUM_BANKS)-1:0]    in_bank,
    input  logic [IDX_W-1:0]                in_index,
    output logic                            out_valid,
    output logic [CH_W-1:0]                 red,
    output logic [CH_W-1:0]                 green,
    output logic [CH_W-1:0]                 blue,
    output logic                            transparent,
    input  logic                            vblank,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [bank_w(NUM_BANKS)-1:0]    wr_bank,
    input  logic [IDX_W-1:0]                wr_index,
    input  logic [3*CH_W-1:0]               wr_rgb,
    input  logic                            frame_tick,
    input  logic                            flash_start,
    output logic                            flash_active
);

    localparam int               BW       = bank_w(NUM_BANKS);
    localparam int               DW       = 3 * CH_W;
    localparam logic [BW:0]      NB       = (BW + 1)'(NUM_BANKS);
    localparam logic [IDX_W-1:0] TRANSP_K = IDX_W'(TRANSP_IDX);

    logic             wr_fire;
    logic             s1_valid_q, s1_valid_d;
    logic [BW-1:0]    s1_bank_q,  s1_bank_d;
    logic [IDX_W-1:0] s1_index_q, s1_index_d;
    logic             s2_valid_q, s2_valid_d;
    logic [BW-1:0]    s2_bank_q,  s2_bank_d;
    logic             s2_blank_q, s2_blank_d;
    logic             s2_flash_q, s2_flash_d;
    logic             flash_force;
    logic [DW-1:0]    rd_data [NUM_BANKS];
    logic [DW-1:0]    rgb_sel;
    logic [DW-1:0]    rgb_out;

    // Write handshake: ready is purely combinational from vblank.
    always_comb begin
        wr_ready = (WR_VBLANK_ONLY == 0) || vblank;
        wr_fire  = wr_valid && wr_ready;
    end

    // Bank storage; an out-of-range wr_bank matches no bank, so it is dropped.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        palette_bank_ram #(
            .IDX_W (IDX_W),
            .CH_W  (CH_W)
        ) u_ram (
            .clk   (Clk),
            .rst_n (Reset_n),
            .we    (wr_fire && (wr_bank == BW'(b))),
            .waddr (wr_index),
            .wdata (wr_rgb),
            .re    (s1_valid_q && (s1_bank_q == BW'(b))),
            .raddr (s1_index_q),
            .rdata (rd_data[b])
        );
    end

`ifdef PALETTE_FLASH_EN
    logic [4:0] flash_cnt_q, flash_cnt_d;

    // Flash counter: start/reload beats a coincident frame tick.
    always_comb begin
        flash_cnt_d = flash_cnt_q;
        if (flash_start) begin
            flash_cnt_d = FLASH_FRAMES;
        end else if (frame_tick && (flash_cnt_q != '0)) begin
            flash_cnt_d = flash_cnt_q - 5'd1;
        end
        flash_active = (flash_cnt_q != '0);
        flash_force  = flash_cnt_q[1];
    end

    // Flash counter register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flash_cnt_q <= '0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
        end
    end
`else
    logic flash_unused;

    // Flash disabled: inputs ignored, no forcing.
    always_comb begin
        flash_unused = flash_start ^ frame_tick;
        flash_active = 1'b0;
        flash_force  = 1'b0;
    end
`endif

    // Pipeline next-state; stage-2 tags only move with a valid pixel so
    // the colour outputs hold while out_valid is low.
    always_comb begin
        s1_valid_d = in_valid;
        s1_bank_d  = in_bank;
        s1_index_d = in_index;
        s2_valid_d = s1_valid_q;
        s2_bank_d  = s2_bank_q;
        s2_blank_d = s2_blank_q;
        s2_flash_d = s2_flash_q;
        if (s1_valid_q) begin
            s2_bank_d  = s1_bank_q;
            s2_blank_d = ({1'b0, s1_bank_q} >= NB) ||
                         ((TRANSP_EN != 0) && (s1_index_q == TRANSP_K));
            s2_flash_d = flash_force;
        end
    end

    // Pipeline registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q <= 1'b0;
            s1_bank_q  <= '0;
            s1_index_q <= '0;
            s2_valid_q <= 1'b0;
            s2_bank_q  <= '0;
            s2_blank_q <= 1'b0;
            s2_flash_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bank_q  <= s1_bank_d;
            s1_index_q <= s1_index_d;
            s2_valid_q <= s2_valid_d;
            s2_bank_q  <= s2_bank_d;
            s2_blank_q <= s2_blank_d;
            s2_flash_q <= s2_flash_d;
        end
    end

    // Output select: bank mux, then transparency/out-of-range blanking and flash.
    always_comb begin
        rgb_sel = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (s2_bank_q == BW'(b)) begin
                rgb_sel = rd_data[b];
            end
        end
        if (s2_blank_q) begin
            rgb_out = '0;
        end else if (s2_flash_q) begin
            rgb_out = '1;
        end else begin
            rgb_out = rgb_sel;
        end
        out_valid   = s2_valid_q;
        transparent = s2_blank_q;
        red         = rgb_out[3*CH_W-1:2*CH_W];
        green       = rgb_out[2*CH_W-1:CH_W];
        blue        = rgb_out[CH_W-1:0];
    end

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Directed bench for sprite_palette_lut (3 banks, so bank 3 is out of range).
module tb_sprite_palette_lut;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        in_valid;
    logic [1:0]  in_bank;
    logic [3:0]  in_index;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic        vblank;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        frame_tick;
    logic        flash_start;
    logic        flash_active;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  bank;
        logic [3:0]  idx;
        logic [11:0] rgb;
        logic        transp;
    } vec_t;

    vec_t        vecs [8];
    logic [11:0] pal  [16];

    always #5 Clk = ~Clk;

    sprite_palette_lut #(
        .IDX_W          (4),
        .CH_W           (4),
        .NUM_BANKS      (3),
        .TRANSP_IDX     (0),
        .TRANSP_EN      (1),
        .WR_VBLANK_ONLY (1)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .in_valid     (in_valid),
        .in_bank      (in_bank),
        .in_index     (in_index),
        .out_valid    (out_valid),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .transparent  (transparent),
        .vblank       (vblank),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_bank      (wr_bank),
        .wr_index     (wr_index),
        .wr_rgb       (wr_rgb),
        .frame_tick   (frame_tick),
        .flash_start  (flash_start),
        .flash_active (flash_active)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // One isolated read; returns outputs sampled two edges after the request.
    task automatic do_read(input logic [1:0] b, input logic [3:0] i,
                           output logic v, output logic [11:0] rgb, output logic t);
        in_valid = 1'b1;
        in_bank  = b;
        in_index = i;
        tick();
        in_valid = 1'b0;
        tick();
        v   = out_valid;
        rgb = {red, green, blue};
        t   = transparent;
    endtask

    task automatic read_chk(input string name, input logic [1:0] b, input logic [3:0] i,
                            input logic [11:0] exp_rgb, input logic exp_t);
        logic v, t;
        logic [11:0] rgb;
        do_read(b, i, v, rgb, t);
        chk({name, "_valid"}, 32'(v), 32'd1);
        chk({name, "_rgb"}, 32'(rgb), 32'(exp_rgb));
        chk({name, "_transp"}, 32'(t), 32'(exp_t));
    endtask

    task automatic pulse_tick;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    initial begin
        pal = '{12'h000, 12'h000, 12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF,
                12'h888, 12'h444, 12'hF80, 12'h840, 12'hFCA, 12'h08F, 12'h8F8, 12'h000};
        // index 8..15 reordered below to match the palette definition
        pal[8]  = 12'hF0F; pal[9]  = 12'h888; pal[10] = 12'h444; pal[11] = 12'hF80;
        pal[12] = 12'h840; pal[13] = 12'hFCA; pal[14] = 12'h08F; pal[15] = 12'h8F8;

        vecs[0] = '{bank: 2'd0, idx: 4'd1,  rgb: 12'h000, transp: 1'b0};
        vecs[1] = '{bank: 2'd0, idx: 4'd0,  rgb: 12'h000, transp: 1'b1};
        vecs[2] = '{bank: 2'd1, idx: 4'd2,  rgb: 12'hFFF, transp: 1'b0};
        vecs[3] = '{bank: 2'd2, idx: 4'd3,  rgb: 12'hF00, transp: 1'b0};
        vecs[4] = '{bank: 2'd2, idx: 4'd15, rgb: 12'h8F8, transp: 1'b0};
        vecs[5] = '{bank: 2'd3, idx: 4'd4,  rgb: 12'h000, transp: 1'b1};
        vecs[6] = '{bank: 2'd1, idx: 4'd0,  rgb: 12'h000, transp: 1'b1};
        vecs[7] = '{bank: 2'd0, idx: 4'd9,  rgb: 12'h888, transp: 1'b0};

        Reset_n = 1'b0; in_valid = 1'b0; in_bank = '0; in_index = '0;
        vblank = 1'b0; wr_valid = 1'b0; wr_bank = '0; wr_index = '0; wr_rgb = '0;
        frame_tick = 1'b0; flash_start = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk("rst_transp", 32'(transparent), 32'd0);
        chk("rst_flash", 32'(flash_active), 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();

        // Default-table vectors, including transparency and out-of-range bank
        for (int k = 0; k < 8; k++) begin
            read_chk($sformatf("vec%0d", k), vecs[k].bank, vecs[k].idx, vecs[k].rgb, vecs[k].transp);
        end

        // Outputs hold when out_valid drops
        tick();
        chk("hold_valid", 32'(out_valid), 32'd0);
        chk("hold_rgb", 32'({red, green, blue}), 32'h888);

        // Write blocked outside vblank
        vblank = 1'b0; wr_valid = 1'b1; wr_bank = 2'd2; wr_index = 4'd5; wr_rgb = 12'h123;
        #1;
        chk("wr_ready_low", 32'(wr_ready), 32'd0);
        tick();
        wr_valid = 1'b0;
        read_chk("wr_blocked", 2'd2, 4'd5, 12'h00F, 1'b0);

        // Write accepted during vblank
        vblank = 1'b1; wr_valid = 1'b1; wr_rgb = 12'hF0F;
        #1;
        chk("wr_ready_high", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        read_chk("wr_b2i5", 2'd2, 4'd5, 12'hF0F, 1'b0);
        read_chk("wr_b0i5", 2'd0, 4'd5, 12'h00F, 1'b0);

        // Collision: stage-2 read and write of the same entry at one edge
        in_valid = 1'b1; in_bank = 2'd1; in_index = 4'd3;
        tick();
        in_valid = 1'b0;
        wr_valid = 1'b1; wr_bank = 2'd1; wr_index = 4'd3; wr_rgb = 12'h123;
        tick();
        wr_valid = 1'b0;
        chk("coll_valid", 32'(out_valid), 32'd1);
        chk("coll_old", 32'({red, green, blue}), 32'hF00);
        read_chk("coll_new", 2'd1, 4'd3, 12'h123, 1'b0);

        // Back-to-back stream of indices 0..15 on bank 0
        for (int c = 0; c < 18; c++) begin
            tick();
            if (c >= 2) begin
                chk($sformatf("strm%0d_valid", c - 2), 32'(out_valid), 32'd1);
                chk($sformatf("strm%0d_rgb", c - 2), 32'({red, green, blue}), 32'(pal[c - 2]));
                chk($sformatf("strm%0d_transp", c - 2), 32'(transparent), (c == 2) ? 32'd1 : 32'd0);
            end
            if (c < 16) begin
                in_valid = 1'b1; in_bank = 2'd0; in_index = c[3:0];
            end else begin
                in_valid = 1'b0;
            end
        end
        tick();
        chk("strm_end_valid", 32'(out_valid), 32'd0);

        // Write to nonexistent bank 3: handshake completes, no table change
        wr_valid = 1'b1; wr_bank = 2'd3; wr_index = 4'd2; wr_rgb = 12'h0AB;
        #1;
        chk("oob_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        read_chk("oob_b0", 2'd0, 4'd2, 12'hFFF, 1'b0);
        read_chk("oob_b1", 2'd1, 4'd2, 12'hFFF, 1'b0);
        read_chk("oob_b2", 2'd2, 4'd2, 12'hFFF, 1'b0);

`ifdef PALETTE_FLASH_EN
        // Flash: 16 frames active, forcing while counter bit 1 is set
        flash_start = 1'b1;
        tick();
        flash_start = 1'b0;
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("flash%0d_active", n), 32'(flash_active), 32'd1);
            read_chk($sformatf("flash%0d", n), 2'd0, 4'd3,
                     (((16 - n) & 2) != 0) ? 12'hFFF : 12'hF00, 1'b0);
            if (n == 1) begin
                read_chk("flash_transp", 2'd0, 4'd0, 12'h000, 1'b1);
            end
            pulse_tick();
        end
        chk("flash_done", 32'(flash_active), 32'd0);
        read_chk("flash_off", 2'd0, 4'd3, 12'hF00, 1'b0);

        // Reload wins over a coincident frame tick (15 -> 16, not 14)
        flash_start = 1'b1;
        tick();
        flash_start = 1'b0;
        pulse_tick();
        flash_start = 1'b1; frame_tick = 1'b1;
        tick();
        flash_start = 1'b0; frame_tick = 1'b0;
        read_chk("flash_reload", 2'd0, 4'd3, 12'hF00, 1'b0);
        pulse_tick();
        read_chk("flash_reload_dec", 2'd0, 4'd3, 12'hFFF, 1'b0);
        chk("flash_mid_active", 32'(flash_active), 32'd1);
`else
        // Flash disabled: start and ticks have no effect
        flash_start = 1'b1;
        tick();
        flash_start = 1'b0;
        pulse_tick();
        chk("noflash_active", 32'(flash_active), 32'd0);
        read_chk("noflash_rgb", 2'd0, 4'd3, 12'hF00, 1'b0);
`endif

        // Reset mid-pipeline (and mid-flash when enabled) discards everything
        in_valid = 1'b1; in_bank = 2'd2; in_index = 4'd5;
        tick();
        Reset_n = 1'b0;
        #1;
        chk("mrst_flash", 32'(flash_active), 32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_rgb", 32'({red, green, blue}), 32'd0);
        in_valid = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        chk("mrst_post_valid", 32'(out_valid), 32'd0);
        read_chk("mrst_b2i5", 2'd2, 4'd5, 12'h00F, 1'b0);
        read_chk("mrst_b1i3", 2'd1, 4'd3, 12'hF00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
